// File: rtl/fifo_wr_ctrl.sv
// Write-domain half of an async FIFO: binary RAM address, write enable, registered gray pointer,
// full flag, occupancy count and sticky overflow. Optional almost_full via FIFO_WR_ALMOST_FULL_EN.
module fifo_wr_ctrl #(
  parameter int P_SIZE   = 5,
  parameter int AF_LEVEL = 12
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_inc,
  input  logic              w_ovf_clr,
  input  logic [P_SIZE-1:0] sync_rd_ptr,
  output logic [P_SIZE-2:0] wr_addr,
  output logic              w_en,
  output logic              full,
  output logic [P_SIZE-1:0] gray_wr_ptr,
  output logic [P_SIZE-1:0] w_count,
  output logic              overflow
`ifdef FIFO_WR_ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  localparam int DEPTH = 1 << (P_SIZE - 1);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("fifo_wr_ctrl: AF_LEVEL must lie in 1..DEPTH");
  end

  logic [P_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_SIZE-1:0] gray_q, gray_d;
  logic              full_q, full_d;
  logic [P_SIZE-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [P_SIZE-1:0] rd_bin;
  logic [P_SIZE-1:0] full_match;

  // Each binary bit is the XOR of all gray bits at or above it.
  for (genvar gi = 0; gi < P_SIZE; gi++) begin : g_rd_bin
    assign rd_bin[gi] = ^sync_rd_ptr[P_SIZE-1:gi];
  end

  // Gray pointer one lap ahead of the reader: top two gray bits inverted.
  assign full_match = {~sync_rd_ptr[P_SIZE-1:P_SIZE-2], sync_rd_ptr[P_SIZE-3:0]};

  assign w_en = w_inc & ~full_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(P_SIZE-1){1'b0}}, w_en};
    gray_d   = wr_ptr_d ^ (wr_ptr_d >> 1);
    full_d   = (gray_d == full_match);
    count_d  = wr_ptr_d - rd_bin;
    ovf_d    = ovf_q;
    if (w_inc && full_q) begin
      ovf_d = 1'b1;
    end else if (w_ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wr_ptr_q <= '0;
      gray_q   <= '0;
      full_q   <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      gray_q   <= gray_d;
      full_q   <= full_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_addr     = wr_ptr_q[P_SIZE-2:0];
  assign full        = full_q;
  assign gray_wr_ptr = gray_q;
  assign w_count     = count_q;
  assign overflow    = ovf_q;

`ifdef FIFO_WR_ALMOST_FULL_EN
  logic af_q, af_d;

  always_comb begin
    af_d = (32'(count_d) >= AF_LEVEL);
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: a binary-domain model pushes expected register values to a
// scoreboard queue each step; they are popped and compared one edge later.
module tb_fifo_wr_ctrl;

  localparam int P  = 5;
  localparam int AF = 12;

  logic         w_clk = 1'b0;
  logic         w_rst = 1'b1;
  logic         w_inc = 1'b0;
  logic         w_ovf_clr = 1'b0;
  logic [P-1:0] sync_rd_ptr = '0;
  logic [P-2:0] wr_addr;
  logic         w_en;
  logic         full;
  logic [P-1:0] gray_wr_ptr;
  logic [P-1:0] w_count;
  logic         overflow;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic         almost_full;
`endif

  fifo_wr_ctrl #(.P_SIZE(P), .AF_LEVEL(AF)) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_inc       (w_inc),
    .w_ovf_clr   (w_ovf_clr),
    .sync_rd_ptr (sync_rd_ptr),
    .wr_addr     (wr_addr),
    .w_en        (w_en),
    .full        (full),
    .gray_wr_ptr (gray_wr_ptr),
    .w_count     (w_count),
    .overflow    (overflow)
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [P-2:0] addr;
    logic [P-1:0] gray;
    logic         full;
    logic [P-1:0] cnt;
    logic         ovf;
    logic         af;
  } exp_t;

  exp_t sb[$];

  int passed = 0;
  int total  = 0;

  // Reference model state, kept in binary.
  logic [P-1:0] m_ptr  = '0;
  logic         m_full = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [P-1:0] m_cnt  = '0;
  logic         m_af   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock of stimulus: rd_b is the reader's binary pointer, driven as gray.
  task automatic step(input logic inc, input logic clr, input logic rst, input logic [P-1:0] rd_b);
    logic   en;
    logic [P-1:0] nxt;
    exp_t   e;
    exp_t   got;
    w_inc       = inc;
    w_ovf_clr   = clr;
    w_rst       = rst;
    sync_rd_ptr = rd_b ^ (rd_b >> 1);
    #1;
    en = inc & ~m_full;
    if (!rst) begin
      chk("w_en", 32'(w_en), 32'(en));
      chk("wr_addr_pre", 32'(wr_addr), 32'(m_ptr[P-2:0]));
    end
    if (rst) begin
      m_ptr = '0; m_full = 1'b0; m_cnt = '0; m_ovf = 1'b0; m_af = 1'b0;
    end else begin
      nxt = m_ptr + P'(en);
      m_cnt = nxt - rd_b;
      if (inc && m_full) m_ovf = 1'b1;
      else if (clr)      m_ovf = 1'b0;
      m_full = (m_cnt == P'(1 << (P - 1)));
      m_af   = (32'(m_cnt) >= AF);
      m_ptr  = nxt;
    end
    e.addr = m_ptr[P-2:0];
    e.gray = m_ptr ^ (m_ptr >> 1);
    e.full = m_full;
    e.cnt  = m_cnt;
    e.ovf  = m_ovf;
    e.af   = m_af;
    sb.push_back(e);
    @(posedge w_clk);
    #1;
    got = sb.pop_front();
    chk("wr_addr", 32'(wr_addr), 32'(got.addr));
    chk("gray_wr_ptr", 32'(gray_wr_ptr), 32'(got.gray));
    chk("full", 32'(full), 32'(got.full));
    chk("w_count", 32'(w_count), 32'(got.cnt));
    chk("overflow", 32'(overflow), 32'(got.ovf));
`ifdef FIFO_WR_ALMOST_FULL_EN
    chk("almost_full", 32'(almost_full), 32'(got.af));
`endif
    $display("step inc=%b clr=%b rst=%b rd=%0d -> addr=%0d gray=%b full=%b cnt=%0d ovf=%b",
             inc, clr, rst, rd_b, wr_addr, gray_wr_ptr, full, w_count, overflow);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [P-1:0] rd;
    @(posedge w_clk);
    #1;
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("reset_gray", 32'(gray_wr_ptr), 32'h0);
    chk("reset_count", 32'(w_count), 32'h0);

    // Fill from empty to full.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, '0);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_count", 32'(w_count), 32'd16);
    chk("fill_gray", 32'(gray_wr_ptr), 32'b11000);

    // Writes while full: blocked, overflow set and sticky; set beats clear.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("ovf_cleared", 32'(overflow), 32'h0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("ovf_set_wins", 32'(overflow), 32'h1);
    step(1'b0, 1'b1, 1'b0, '0);

    // Reader advances by one: full drops a cycle later, then one write refills.
    step(1'b0, 1'b0, 1'b0, 5'd1);
    chk("drain_count", 32'(w_count), 32'd15);
    step(1'b1, 1'b0, 1'b0, 5'd1);
    chk("refill_full", 32'(full), 32'h1);

    // Reader trails the writer by two entries across a pointer wrap.
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 40; i++) begin
      rd = m_ptr - 5'd1;
      step(1'b1, 1'b0, 1'b0, rd);
    end
    chk("track_count", 32'(w_count), 32'd2);
    chk("track_ptr", 32'(m_ptr), 32'd10);

    // Reset mid-stream with a write request pending.
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, '0);
    chk("pre_rst_addr", 32'(wr_addr), 32'd7);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("post_rst_addr", 32'(wr_addr), 32'd0);

    // Almost-full threshold and release.
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, '0);
`ifdef FIFO_WR_ALMOST_FULL_EN
    chk("af_below", 32'(almost_full), 32'h0);
`endif
    step(1'b1, 1'b0, 1'b0, '0);
`ifdef FIFO_WR_ALMOST_FULL_EN
    chk("af_at_level", 32'(almost_full), 32'h1);
`endif
    step(1'b0, 1'b0, 1'b0, 5'd1);
    chk("af_release_count", 32'(w_count), 32'd11);
`ifdef FIFO_WR_ALMOST_FULL_EN
    chk("af_released", 32'(almost_full), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-domain controller of the async FIFO, the counterpart of the read-side pointer/empty logic.
- Generates the binary write address, the memory write enable and a registered gray-coded write pointer for the read domain.
- Derives a registered full flag, a write-side occupancy count and a sticky overflow error from the synchronized gray read pointer.
- Sits between the producer and the dual-port FIFO RAM, single clock (write domain).

Parameters:
- P_SIZE, 5: pointer width; address width P_SIZE-1; depth DEPTH = 2^(P_SIZE-1) (16 at default).
- AF_LEVEL, 12: almost-full threshold in entries, 1..DEPTH; used only with the optional feature.

Ports:
- w_clk  input  1  write domain operating clock
- w_rst  input  1  synchronous active-high reset
- w_inc  input  1  write request from producer
- w_ovf_clr  input  1  clears the sticky overflow flag
- sync_rd_ptr  input  P_SIZE  gray read pointer, already synchronized into w_clk
- wr_addr  output  P_SIZE-1  binary write address to RAM
- w_en  output  1  RAM write enable
- full  output  1  FIFO full flag
- gray_wr_ptr  output  P_SIZE  registered gray write pointer, to the read-domain synchronizer
- w_count  output  P_SIZE  entries in use, as seen from the write side (0..DEPTH)
- overflow  output  1  sticky: write attempted while full
- almost_full  output  1  present only with FIFO_WR_ALMOST_FULL_EN

Behaviour:
- Reset:
  - Interface: one clock; reset is synchronous and active-high; clock w_clk, reset w_rst.
  - With w_rst high at a w_clk edge: binary wr_ptr=0, gray_wr_ptr=0, full=0, w_count=0, overflow=0, almost_full=0.
  - w_inc is ignored while w_rst is high; reset has priority over all other events.
- Write acceptance:
  - w_en = w_inc & ~full, combinational; it is the only condition that advances the pointer.
  - wr_addr = wr_ptr[P_SIZE-2:0]; data is written to RAM at wr_addr on the edge where w_en=1.
- Pointer:
  - wr_next = wr_ptr + w_en, modulo 2^P_SIZE (natural wrap 2^P_SIZE-1 -> 0).
  - Registered on every edge; gray_wr_ptr <= wr_next ^ (wr_next >> 1).
  - Gray output comes straight from a flop, never from combinational logic.
- Read-pointer conversion:
  - rd_bin = gray-to-binary of sync_rd_ptr (MSB copied; rd_bin[i] = rd_bin[i+1] ^ sync_rd_ptr[i]).
- Full:
  - full <= (gray(wr_next) == {~sync_rd_ptr[P_SIZE-1:P_SIZE-2], sync_rd_ptr[P_SIZE-3:0]}).
  - Asserts on the same edge that accepts the DEPTH-th outstanding write.
  - Deasserts one w_clk after sync_rd_ptr advances. This one-cycle pessimism is intentional.
- Count:
  - w_count <= (wr_next - rd_bin) mod 2^P_SIZE, registered.
  - Invariant: full == (w_count == DEPTH).
- Overflow:
  - overflow <= 1 when w_inc & full.
  - Else cleared when w_ovf_clr; else holds.
  - Simultaneous w_inc & full and w_ovf_clr: set wins.
- Simultaneous write and read-pointer change in one cycle: both are used in that edge's full/count computation. No lost update.
- Reset mid-operation: pointers return to 0 regardless of sync_rd_ptr. The read side must be reset in the same window, otherwise count/full are undefined until it is.

Optional Feature:
- Macro: FIFO_WR_ALMOST_FULL_EN.
- Defined:
  - Adds port almost_full, almost_full <= ((wr_next - rd_bin) mod 2^P_SIZE) >= AF_LEVEL.
  - Registered and aligned with w_count; reset 0.
- Undefined: no almost_full port and no comparator logic; AF_LEVEL unused.

Test Plan:
- Reset, sync_rd_ptr=00000, 16 cycles w_inc=1 -> w_en=1 each cycle.
  - wr_addr steps 0..15; after the 16th edge full=1, w_count=16, gray_wr_ptr=11000.
- From full, w_inc=1 for 2 cycles -> w_en=0, wr_addr stays 0, gray_wr_ptr stays 11000.
  - overflow=1 after the first edge and holds; w_ovf_clr=1 with w_inc=0 -> overflow=0 next edge.
- From full, drive sync_rd_ptr=00001 (rd_bin=1) -> full=0 and w_count=15 one edge later.
  - A write on that cycle is accepted at wr_addr=0.
- Reader tracks writer (sync_rd_ptr = gray of wr_ptr-2), 40 writes -> full never asserts, w_count stays 2.
  - Pointer wraps 31->0, gray_wr_ptr goes 10000->00000, wr_addr wraps 15->0.
- Assert w_rst at wr_ptr=7 with w_inc=1 -> next edge: wr_addr=0, gray_wr_ptr=0, full=0, w_count=0, overflow=0.
  - No pointer advance while w_rst is high.
- FIFO_WR_ALMOST_FULL_EN, AF_LEVEL=12, sync_rd_ptr=0 -> almost_full=0 after 11 writes, 1 on the edge of the 12th write.
  - almost_full returns to 0 when sync_rd_ptr moves to gray(1)=00001 with w_count=11.
